// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache way controller.
package cache_ctrl_pkg;
   localparam int NUM_WAYS_DEF = 4;
   localparam int WAY_W_DEF    = $clog2(NUM_WAYS_DEF);

   typedef logic [WAY_W_DEF-1:0] way_idx_t;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

   localparam logic DIRTY_SET = 1'b1;
   localparam logic DIRTY_CLR = 1'b0;
endpackage

// File: rtl/cache_way_ctrl_prio_enc.sv
// onehot_prio_enc: lowest-set-bit priority encoder with a found flag.
module onehot_prio_enc #(
   parameter int num_ways = 4,
   parameter int width    = $clog2(num_ways)
) (
   input  logic [num_ways-1:0] vec,
   output logic [width-1:0]    idx,
   output logic                found
);
   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = num_ways-1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = width'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cache_way_ctrl.sv
// Cache way control FSM: hit/miss, victim selection, writeback/fill, LRU update.
// Optional: CACHE_INVALID_FIRST_EN prefers an invalid way as victim over lru_way.
module cache_way_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int num_ways = 4,
   parameter int width    = $clog2(num_ways)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   output logic                mem_resp,
   input  logic [num_ways-1:0] hit_vec,
   input  logic [num_ways-1:0] valid_vec,
   input  logic                victim_dirty,
   input  logic [width-1:0]    lru_way,
   output logic                lru_read,
   output logic                lru_load,
   output logic [width-1:0]    lru_recent,
   output logic [width-1:0]    way_sel,
   output logic [num_ways-1:0] tag_load,
   output logic [num_ways-1:0] valid_load,
   output logic [num_ways-1:0] dirty_load,
   output logic [num_ways-1:0] data_load,
   output logic                dirty_in,
   output logic                data_src,
   output logic                addr_sel,
   output logic                pmem_read,
   output logic                pmem_write,
   input  logic                pmem_resp
);
   localparam logic [num_ways-1:0] ONE = num_ways'(1);

   state_t           state;
   logic [width-1:0] victim;
   logic [width-1:0] hit_way;
   logic             hit_found;
   logic [width-1:0] inv_way;
   logic             inv_found;
   logic [width-1:0] miss_victim;

   onehot_prio_enc #(.num_ways(num_ways), .width(width)) u_hit_enc (
      .vec   (hit_vec),
      .idx   (hit_way),
      .found (hit_found)
   );

   onehot_prio_enc #(.num_ways(num_ways), .width(width)) u_inv_enc (
      .vec   (~valid_vec),
      .idx   (inv_way),
      .found (inv_found)
   );

`ifdef CACHE_INVALID_FIRST_EN
   assign miss_victim = inv_found ? inv_way : lru_way;
`else
   logic unused_inv;
   assign unused_inv  = ^{inv_way, inv_found};
   assign miss_victim = lru_way;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         victim <= '0;
      end else begin
         case (state)
            IDLE:      if (mem_read || mem_write) state <= COMPARE;
            COMPARE: begin
               if (hit_found) state <= IDLE;
               else begin
                  victim <= miss_victim;
                  state  <= (victim_dirty && valid_vec[miss_victim]) ? WRITEBACK : FILL;
               end
            end
            WRITEBACK: if (pmem_resp) state <= FILL;
            FILL:      if (pmem_resp) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   // Hit and fill-completion strobes depend on same-cycle datapath/memory inputs.
   always_comb begin
      mem_resp   = 1'b0;
      lru_read   = 1'b0;
      lru_load   = 1'b0;
      lru_recent = '0;
      way_sel    = '0;
      tag_load   = '0;
      valid_load = '0;
      dirty_load = '0;
      data_load  = '0;
      dirty_in   = DIRTY_CLR;
      data_src   = 1'b0;
      addr_sel   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      case (state)
         IDLE: lru_read = mem_read | mem_write;
         COMPARE: begin
            if (hit_found) begin
               mem_resp   = 1'b1;
               lru_load   = 1'b1;
               lru_recent = hit_way;
               way_sel    = hit_way;
               if (mem_write) begin
                  data_load  = ONE << hit_way;
                  dirty_load = ONE << hit_way;
                  dirty_in   = DIRTY_SET;
               end
            end else begin
               way_sel = miss_victim;
            end
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = 1'b1;
            way_sel    = victim;
         end
         FILL: begin
            pmem_read = 1'b1;
            way_sel   = victim;
            if (pmem_resp) begin
               tag_load   = ONE << victim;
               valid_load = ONE << victim;
               dirty_load = ONE << victim;
               data_load  = ONE << victim;
               dirty_in   = DIRTY_CLR;
               data_src   = 1'b1;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl; follows CACHE_INVALID_FIRST_EN if defined.
module tb_cache_way_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read, mem_write, mem_resp;
   logic [3:0] hit_vec, valid_vec;
   logic       victim_dirty;
   logic [1:0] lru_way;
   logic       lru_read, lru_load;
   logic [1:0] lru_recent, way_sel;
   logic [3:0] tag_load, valid_load, dirty_load, data_load;
   logic       dirty_in, data_src, addr_sel, pmem_read, pmem_write, pmem_resp;

   int total  = 0;
   int passed = 0;

   cache_way_ctrl #(.num_ways(4), .width(2)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .hit_vec(hit_vec), .valid_vec(valid_vec), .victim_dirty(victim_dirty),
      .lru_way(lru_way), .lru_read(lru_read), .lru_load(lru_load),
      .lru_recent(lru_recent), .way_sel(way_sel),
      .tag_load(tag_load), .valid_load(valid_load),
      .dirty_load(dirty_load), .data_load(data_load),
      .dirty_in(dirty_in), .data_src(data_src), .addr_sel(addr_sel),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   wire [27:0] outs = {mem_resp, lru_read, lru_load, lru_recent, way_sel,
                       tag_load, valid_load, dirty_load, data_load,
                       dirty_in, data_src, addr_sel, pmem_read, pmem_write};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // A multi-bit hit vector would be a datapath fault.
   always @(negedge clk) begin
      if (!rst) begin
         assert ($onehot0(hit_vec))
         else begin
            total++;
            $error("FAIL hit_onehot: got %b expected onehot0", hit_vec);
         end
      end
   end

   initial begin
      rst = 1'b1; mem_read = 0; mem_write = 0; hit_vec = 0; valid_vec = 4'b1111;
      victim_dirty = 0; lru_way = 0; pmem_resp = 0;
      tick(); tick();
      rst = 1'b0; #1;
      chk("reset_outs", 32'(outs), 0);

      // read hit on way 1
      mem_read = 1; #1;
      chk("rd_hit_lru_read", 32'(lru_read), 1);
      chk("rd_hit_no_resp_c0", 32'(mem_resp), 0);
      tick(); hit_vec = 4'b0010; #1;
      chk("rd_hit_resp", 32'(mem_resp), 1);
      chk("rd_hit_lru_load", 32'(lru_load), 1);
      chk("rd_hit_recent", 32'(lru_recent), 1);
      chk("rd_hit_way_sel", 32'(way_sel), 1);
      chk("rd_hit_no_data", 32'(data_load), 0);
      tick(); mem_read = 0; hit_vec = 0; #1;
      chk("rd_hit_idle", 32'(outs), 0);

      // write hit on way 3
      mem_write = 1; tick(); hit_vec = 4'b1000; #1;
      chk("wr_hit_resp", 32'(mem_resp), 1);
      chk("wr_hit_data", 32'(data_load), 32'b1000);
      chk("wr_hit_dirty", 32'(dirty_load), 32'b1000);
      chk("wr_hit_din_src", 32'({dirty_in, data_src}), 32'b10);
      chk("wr_hit_recent", 32'(lru_recent), 3);
      tick(); mem_write = 0; hit_vec = 0;

      // clean read miss, lru victim 2
      mem_read = 1; tick(); lru_way = 2; #1;
      chk("rmiss_way_sel", 32'(way_sel), 2);
      chk("rmiss_no_resp", 32'(mem_resp), 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rmiss_fill_hold", 32'({pmem_read, pmem_write, addr_sel, way_sel}), 32'b10010);
         chk("rmiss_fill_nowr", 32'(data_load), 0);
         tick();
      end
      pmem_resp = 1; #1;
      chk("rmiss_fill_tag", 32'(tag_load), 32'b0100);
      chk("rmiss_fill_valid", 32'(valid_load), 32'b0100);
      chk("rmiss_fill_data", 32'(data_load), 32'b0100);
      chk("rmiss_fill_din_src", 32'({dirty_in, data_src}), 32'b01);
      chk("rmiss_fill_no_resp", 32'(mem_resp), 0);
      tick(); pmem_resp = 0; #1;
      chk("rmiss_idle_relookup", 32'({lru_read, pmem_read}), 32'b10);
      tick(); hit_vec = 4'b0100; #1;
      chk("rmiss_resp", 32'(mem_resp), 1);
      tick(); mem_read = 0; hit_vec = 0;

      // dirty write miss, lru victim 3
      mem_write = 1; tick(); lru_way = 3; victim_dirty = 1; #1;
      chk("wmiss_way_sel", 32'(way_sel), 3);
      tick(); #1;
      chk("wmiss_wb", 32'({pmem_write, pmem_read, addr_sel, way_sel}), 32'b10111);
      tick(); pmem_resp = 1; #1;
      chk("wmiss_wb_resp_nowr", 32'(data_load), 0);
      chk("wmiss_wb_hold", 32'(pmem_write), 1);
      tick(); pmem_resp = 0; #1;
      chk("wmiss_fill", 32'({pmem_write, pmem_read, addr_sel, way_sel}), 32'b01011);
      pmem_resp = 1; #1;
      chk("wmiss_fill_tag", 32'(tag_load), 32'b1000);
      chk("wmiss_fill_din", 32'(dirty_in), 0);
      tick(); pmem_resp = 0; tick(); hit_vec = 4'b1000; #1;
      chk("wmiss_hit_data", 32'(data_load), 32'b1000);
      chk("wmiss_hit_din", 32'({dirty_in, mem_resp}), 32'b11);
      tick(); mem_write = 0; hit_vec = 0; victim_dirty = 0;

      // victim choice with an invalid way present
      mem_read = 1; tick(); valid_vec = 4'b1011; lru_way = 0; victim_dirty = 1; #1;
`ifdef CACHE_INVALID_FIRST_EN
      chk("inv_victim", 32'(way_sel), 2);
      tick(); #1;
      chk("inv_no_wb", 32'({pmem_read, pmem_write, way_sel}), 32'b1010);
`else
      chk("lru_victim", 32'(way_sel), 0);
      tick(); #1;
      chk("lru_wb", 32'({pmem_read, pmem_write, way_sel}), 32'b0100);
      pmem_resp = 1; tick(); pmem_resp = 0;
`endif
      // reset during FILL
      tick(); #1;
      chk("fill_before_rst", 32'(pmem_read), 1);
      rst = 1; mem_read = 0; tick(); rst = 0; #1;
      chk("rst_fill_outs", 32'(outs), 0);
      pmem_resp = 1; #1;
      chk("rst_late_resp", 32'(outs), 0);
      tick(); pmem_resp = 0; #1;
      chk("rst_after_resp", 32'(outs), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cache_way_ctrl.md
# cache_way_ctrl

Control FSM for one set-associative cache level. It sequences the tag/valid/dirty arrays, the pseudo-LRU replacement array and the data array for each CPU request. It decides hit or miss, picks the victim way, runs writeback and fill transactions on the physical-memory port, and updates replacement state on every hit. It sits between the CPU-side request port and the cache datapath; all array indexing and address muxing live in the datapath and are steered by this block's select outputs.

## Interface
- `num_ways`, 4: associativity; power of two, ≥2.
- `width`, `$clog2(num_ways)`: way-index width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`. Never asserted together with `mem_read`.
- `mem_resp`  out  1  one-cycle completion pulse to the CPU.
- `hit_vec`  in  num_ways  per-way tag match AND valid; combinational from the datapath.
- `valid_vec`  in  num_ways  per-way valid bits of the indexed set.
- `victim_dirty`  in  1  dirty bit of the way selected by `way_sel`.
- `lru_way`  in  width  registered pseudo-LRU victim; valid the cycle after `lru_read`.
- `lru_read`  out  1  request a victim read from the LRU array.
- `lru_load`  out  1  update the LRU array with `lru_recent`.
- `lru_recent`  out  width  most-recently-used way.
- `way_sel`  out  width  way steering the datapath muxes and victim dirty/tag.
- `tag_load`, `valid_load`, `dirty_load`, `data_load`  out  num_ways each  one-hot per-way write enables.
- `dirty_in`  out  1  value written on `dirty_load`.
- `data_src`  out  1  0 = CPU write data, 1 = `pmem` fill line.
- `addr_sel`  out  1  0 = CPU address, 1 = victim writeback address (victim tag + index).
- `pmem_read`, `pmem_write`  out  1  memory requests; held until `pmem_resp`.
- `pmem_resp`  in  1  one-cycle memory completion.

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: if `mem_read|mem_write`, assert `lru_read` and go to COMPARE. Otherwise stay.
- COMPARE, hit (`|hit_vec`): `hit_way` is the lowest set bit of `hit_vec`.
  - Assert `mem_resp`, `lru_load`, `lru_recent=hit_way` and `way_sel=hit_way`.
  - On write, also assert `data_load[hit_way]`, `dirty_load[hit_way]`, `dirty_in=1` and `data_src=0`.
  - Go to IDLE.
- COMPARE, miss: register `victim` and drive `way_sel=victim`. If `victim_dirty` and `valid_vec[victim]`, go to WRITEBACK; else go to FILL.
- WRITEBACK: `pmem_write=1`, `addr_sel=1`, `way_sel=victim`. On `pmem_resp`, go to FILL.
- FILL: `pmem_read=1`, `addr_sel=0`, `way_sel=victim`. On `pmem_resp`:
  - Assert `data_load`, `tag_load`, `valid_load` and `dirty_load` at `victim`, with `dirty_in=0` and `data_src=1`.
  - Go to IDLE. The still-held request then re-enters and hits.
- All outputs not listed for a state are 0.
- A multi-bit `hit_vec` is a datapath error. The block still uses the lowest way; the bench flags it as an assertion.

## Timing
- Reset: state IDLE, `victim=0`, every output 0. Reset mid-WRITEBACK or mid-FILL drops the `pmem` request in the next cycle without waiting for `pmem_resp`.
- Hit latency: request seen in IDLE at cycle 0, `mem_resp` at cycle 1.
- Clean miss, `pmem_resp` at cycle k: IDLE at k+1, COMPARE at k+2, `mem_resp` at k+2.
- Dirty miss: the writeback `pmem_resp` cycle moves to FILL, and `pmem_read` rises in the next cycle.
- `mem_resp` is never asserted in the same cycle as a `pmem_*` request.
- `pmem_resp` outside WRITEBACK or FILL is ignored.

## Configuration
- `CACHE_INVALID_FIRST_EN` defined: on a miss, if `~valid_vec` is nonzero, `victim` is its lowest set bit; `lru_way` is used only when the set is full.
- Undefined: `victim = lru_way` always.

## Structure
- Package `cache_ctrl_pkg`:
  - `state_t` enum (IDLE, COMPARE, WRITEBACK, FILL);
  - a way-index typedef parameterised through a localparam default;
  - `DIRTY_SET`/`DIRTY_CLR` constants.
- Sub-module `onehot_prio_enc`: lowest-set-bit priority encoder, `num_ways` in, `width` plus a found flag out. It has two instances: hit way and invalid-first victim.

## Test plan
- Read, `hit_vec=0010`: `mem_resp` at cycle 1, `lru_load=1`, `lru_recent=1`, no `data_load`.
- Write, `hit_vec=1000`: `data_load=1000`, `dirty_load=1000`, `dirty_in=1`, `data_src=0`, `mem_resp` at cycle 1.
- Read miss, `lru_way=2`, clean, `pmem_resp` 5 cycles after FILL entry: `pmem_read` held 5 cycles, then `tag/valid/data_load=0100` with `dirty_in=0`; `mem_resp` 2 cycles later.
- Write miss, `lru_way=3`, dirty, valid: WRITEBACK with `addr_sel=1`, then FILL, then a hit that writes way 3 with `dirty_in=1`.
- `CACHE_INVALID_FIRST_EN`, `valid_vec=1011`, `lru_way=0`: victim 2, no WRITEBACK even with `victim_dirty=1`.
- `rst` pulsed during FILL: next cycle IDLE, `pmem_read=0`, all outputs 0; a late `pmem_resp` causes no array write.
